bram_port_arbiter: RTL and testbench

- Parametrised N-requester arbiter for one BRAM port; generalises the 2-way mem_control select between CPU and MemAccess.
- Accepts byte-addressed read/write requests from NUM_REQ masters and issues one registered command per cycle to the BRAM port.
- Supports fixed-priority or round-robin selection, an exclusive-owner lock, and READ_LAT-tracked read-data return routed to the issuing master.

---
 rtl/bram_port_arbiter_if.sv | 38 +++
 rtl/bram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side bundle for the BRAM port arbiter.
// slave: the arbiter; master: requesters plus the BRAM itself.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int MEM_AW  = 13
);
  localparam int BE_W = DATA_W / 8;

  logic                      lock;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*BE_W-1:0]   req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic [BE_W-1:0]           mem_we;
  logic [MEM_AW-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_din;
  logic [DATA_W-1:0]         mem_dout;

  modport slave (
    input  lock, req, req_we, req_addr,
    input  req_wdata, mem_dout,
    output gnt, rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output lock, req, req_we, req_addr,
    output req_wdata, mem_dout,
    input  gnt, rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// N-way arbiter for one BRAM port: RR or fixed priority,
// exclusive lock, and tagged read-data return.
module bram_port_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int MEM_AW   = 13,
  parameter int READ_LAT = 1,
  parameter int RR_MODE  = 1,
  parameter int LOCK_ID  = 1
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int SHIFT = $clog2(BE_W);
  localparam int IDX_W = (NUM_REQ > 1) ?
                         $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE =
    {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] LOCK_MASK =
    ONE << LOCK_ID;
  localparam logic [IDX_W-1:0] PTR_RST =
    IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win, win_q;
  logic               found;
  int                 idx;

  logic [BE_W-1:0]    sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic               mem_en_q;
  logic [BE_W-1:0]    mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;

  logic [READ_LAT-1:0] tv_q;
  logic [IDX_W-1:0]    tid_q [READ_LAT];
  logic                issue_rd;

  // Masks already-granted and, under lock, non-owner requests
  always_comb begin
    elig = bus.req & ~gnt_q;
    if (bus.lock) elig &= LOCK_MASK;
  end

  // Picks the winner, searching from pointer+1 in RR mode
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (RR_MODE != 0)
        idx = (int'(ptr_q) + 1 + k) % NUM_REQ;
      else
        idx = k;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  // Muxes the winning requester's payload
  always_comb begin
    sel_we    = bus.req_we[win*BE_W +: BE_W];
    sel_addr  = bus.req_addr[win*ADDR_W +: ADDR_W];
    sel_wdata = bus.req_wdata[win*DATA_W +: DATA_W];
  end

  // Builds the next command; address/data hold when idle
  always_comb begin
    gnt_d      = '0;
    mem_we_d   = '0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    ptr_d      = ptr_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      mem_we_d   = sel_we;
      mem_addr_d = MEM_AW'(sel_addr >> SHIFT);
      mem_din_d  = sel_wdata;
      if (RR_MODE != 0) ptr_d = win;
    end
  end

  assign issue_rd = mem_en_q && (mem_we_q == '0);

  // Registers the command, grant and RR pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      ptr_q      <= PTR_RST;
      win_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win;
      mem_en_q   <= found;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Shifts read tags so each returns READ_LAT after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
      for (int i = 0; i < READ_LAT; i++)
        tid_q[i] <= '0;
    end else begin
      tv_q[0]  <= issue_rd;
      tid_q[0] <= win_q;
      for (int i = 1; i < READ_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  // Routes the returning tag to its requester's rvalid
  always_comb begin
    bus.rvalid = '0;
    if (tv_q[READ_LAT-1])
      bus.rvalid[tid_q[READ_LAT-1]] = 1'b1;
  end

  assign bus.gnt      = gnt_q;
  assign bus.rdata    = bus.mem_dout;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: 4 requesters, RR,
// READ_LAT=2, LOCK_ID=1, with a BRAM model and read scoreboard.
module tb_bram_port_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int MAW = 13;
  localparam int RL  = 2;
  localparam int BE  = DW / 8;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  bram_port_arbiter_if #(
    .NUM_REQ(N), .DATA_W(DW),
    .ADDR_W(AW), .MEM_AW(MAW)
  ) bif ();

  bram_port_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW),
    .MEM_AW(MAW), .READ_LAT(RL),
    .RR_MODE(1), .LOCK_ID(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [DW-1:0] mem [2**MAW];
  logic [DW-1:0] p1, p2;

  always @(posedge clk) begin
    if (bif.mem_en) begin
      for (int b = 0; b < BE; b++)
        if (bif.mem_we[b])
          mem[bif.mem_addr][8*b +: 8] <=
            bif.mem_din[8*b +: 8];
      p1 <= mem[bif.mem_addr];
    end
    p2 <= p1;
  end
  assign bif.mem_dout = p2;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bif.rvalid !== '0) begin
      chk("rvalid_onehot", $countones(bif.rvalid), 1);
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", bif.rvalid, 0);
      end else begin
        e = sbq.pop_front();
        chk("rvalid_id", bif.rvalid, 4'b0001 << e.id);
        chk("rdata", bif.rdata, e.data);
      end
    end
  end

  task automatic set_req(input int id,
                         input logic [BE-1:0] we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bif.req_we[id*BE +: BE]    = we;
    bif.req_addr[id*AW +: AW]  = a;
    bif.req_wdata[id*DW +: DW] = d;
    bif.req[id]                = 1'b1;
  endtask

  task automatic do_req(input int id,
                        input logic [BE-1:0] we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [MAW-1:0] ea);
    bit got = 1'b0;
    set_req(id, we, a, d);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bif.gnt[id]) begin
        got = 1'b1;
        chk("cmd_en", bif.mem_en, 1);
        chk("cmd_we", bif.mem_we, we);
        chk("cmd_addr", bif.mem_addr, ea);
        chk("cmd_din", bif.mem_din, d);
        bif.req[id] = 1'b0;
      end
    end
    if (!got) chk("gnt_timeout", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bif.gnt, 0);
    chk({tag, "_rvalid"}, bif.rvalid, 0);
    chk({tag, "_en"}, bif.mem_en, 0);
    chk({tag, "_we"}, bif.mem_we, 0);
    chk({tag, "_addr"}, bif.mem_addr, 0);
    chk({tag, "_din"}, bif.mem_din, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bif.lock      = 1'b0;
    bif.req       = '0;
    bif.req_we    = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;

    // all requesters write while reset is held
    for (int i = 0; i < N; i++)
      set_req(i, 4'hF, AW'((i + 1) * 16),
              32'h1000 + i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // round-robin rotation with all requests held
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_gnt", bif.gnt, 4'b0001 << (k % 4));
      chk("rr_en", bif.mem_en, 1);
      chk("rr_addr", bif.mem_addr, (k % 4 + 1) * 4);
      chk("rr_din", bif.mem_din, 32'h1000 + k % 4);
    end
    bif.req = '0;
    @(negedge clk);
    chk("idle_gnt", bif.gnt, 0);
    chk("idle_en", bif.mem_en, 0);
    chk("idle_we", bif.mem_we, 0);
    chk("idle_addr_hold", bif.mem_addr, 13'h010);
    chk("idle_din_hold", bif.mem_din, 32'h1003);

    // address shift, read-back, and truncation
    do_req(2, 4'hF, 16'h0104, 32'hDEADBEEF, 13'h041);
    sbq.push_back('{id: 2'd2, data: 32'hDEADBEEF});
    do_req(2, 4'h0, 16'h0104, 32'h0, 13'h041);
    do_req(3, 4'hF, 16'hFFFC, 32'hA5A50001, 13'h1FFF);
    sbq.push_back('{id: 2'd3, data: 32'hA5A50001});
    do_req(3, 4'h0, 16'hFFFC, 32'h0, 13'h1FFF);

    // back-to-back reads from requesters 0 and 1
    do_req(0, 4'hF, 16'h0000, 32'h11110000, 13'h0);
    do_req(1, 4'hF, 16'h0004, 32'h22220004, 13'h1);
    repeat (3) @(negedge clk);
    chk("sb_drain1", sbq.size(), 0);
    sbq.push_back('{id: 2'd0, data: 32'h11110000});
    sbq.push_back('{id: 2'd1, data: 32'h22220004});
    set_req(0, 4'h0, 16'h0000, 32'h0);
    set_req(1, 4'h0, 16'h0004, 32'h0);
    @(negedge clk);
    chk("b2b_gnt0", bif.gnt, 4'b0001);
    bif.req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_gnt1", bif.gnt, 4'b0010);
    bif.req[1] = 1'b0;
    @(negedge clk);
    chk("b2b_rv0", bif.rvalid, 4'b0001);
    @(negedge clk);
    chk("b2b_rv1", bif.rvalid, 4'b0010);
    @(negedge clk);
    chk("sb_drain2", sbq.size(), 0);

    // lock: only requester 1 may be granted
    bif.lock = 1'b1;
    set_req(0, 4'hF, 16'h0008, 32'h33330008);
    set_req(1, 4'hF, 16'h000C, 32'h4444000C);
    @(negedge clk);
    chk("lock_gnt", bif.gnt, 4'b0010);
    bif.req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_stall", bif.gnt, 0);
    end
    bif.lock = 1'b0;
    @(negedge clk);
    chk("unlock_gnt", bif.gnt, 4'b0001);
    chk("unlock_addr", bif.mem_addr, 13'h002);
    bif.req[0] = 1'b0;

    // reset right after a read issue drops that read
    set_req(2, 4'h0, 16'h0104, 32'h0);
    @(negedge clk);
    chk("pre_rst_gnt", bif.gnt, 4'b0100);
    bif.req[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    @(negedge clk);
    chk_zero("midrst2");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_rvalid", bif.rvalid, 0);
    end
    chk("sb_final", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
